vga_timing_receiver: RTL and testbench

VGA_TIMING_RECEIVER -- requirements
Module: vga_timing_receiver

---
 rtl/vga_timing_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: registers the sync/blank/pixel pins, measures line and frame lengths,
// locks after LOCK_FRAMES good frames and emits coordinates. Define VGA_RX_CHECKSUM_EN for frame_sum.
module vga_timing_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [23:0] rgb,
  output logic        pixel_valid,
  output logic [9:0]  posx,
  output logic [9:0]  posy,
  output logic [23:0] pixel_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic        sync_error,
  output logic [31:0] frame_sum
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int         GOOD_W      = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0] LINE_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] FRAME_LINES = 10'(V_TOTAL);
  localparam logic [9:0] CNT_MAX     = 10'h3FF;

  logic              hs_q, vs_q, blank_q, hs_prev_q, vs_prev_q;
  logic [23:0]       rgb_q;
  state_t            state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d, good_next;
  logic [9:0]        line_cnt_q, line_cnt_d;
  logic [9:0]        line_num_q, line_num_d, lines_seen;
  logic              frame_ok_q, frame_ok_d;
  logic [9:0]        px_q, px_d, py_q, py_d, x_base, y_base;
  logic              line_active_q, line_active_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [9:0]        posx_q, posx_d, posy_q, posy_d;
  logic [23:0]       pixel_rgb_q, pixel_rgb_d;
  logic              locked_q, locked_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_error_q, sync_error_d;
  logic              hs_fall, vs_fall, line_bad, frame_good;

  // Syncs idle high so that leaving reset never fabricates a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      blank_q   <= 1'b0;
      rgb_q     <= 24'd0;
    end else begin
      hs_q      <= vga_hs;
      vs_q      <= vga_vs;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      blank_q   <= vga_blank_n;
      rgb_q     <= rgb;
    end
  end

  // A line ending on the same edge as VS still belongs to the frame being closed.
  always_comb begin
    hs_fall    = hs_prev_q & ~hs_q;
    vs_fall    = vs_prev_q & ~vs_q;
    line_bad   = hs_fall & (line_cnt_q != LINE_LAST);
    line_cnt_d = hs_fall ? 10'd0 : ((line_cnt_q == CNT_MAX) ? CNT_MAX : line_cnt_q + 10'd1);
    lines_seen = line_num_q;
    if (hs_fall && line_num_q != CNT_MAX) lines_seen = line_num_q + 10'd1;
    frame_good = frame_ok_q & ~line_bad & (lines_seen == FRAME_LINES);
    line_num_d = vs_fall ? 10'd0 : lines_seen;
    frame_ok_d = vs_fall ? 1'b1 : (frame_ok_q & ~line_bad);
  end

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    good_next    = good_cnt_q + GOOD_W'(1);
    frame_done_d = 1'b0;
    sync_error_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d    = MEASURE;
          good_cnt_d = '0;
        end
      end
      MEASURE: begin
        if (vs_fall) begin
          if (!frame_good) begin
            good_cnt_d = '0;
          end else if (good_next == GOOD_W'(LOCK_FRAMES)) begin
            state_d      = LOCKED;
            good_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            good_cnt_d = good_next;
          end
        end
      end
      LOCKED: begin
        if (line_bad || (vs_fall && !frame_good)) begin
          state_d      = SEARCH;
          sync_error_d = 1'b1;
        end else if (vs_fall) begin
          frame_done_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);
  end

  // Coordinate outputs hold the last active pixel while blanked.
  always_comb begin
    x_base        = hs_fall ? 10'd0 : px_q;
    y_base        = py_q;
    if (hs_fall && line_active_q) y_base = py_q + 10'd1;
    if (vs_fall) y_base = 10'd0;
    line_active_d = (hs_fall ? 1'b0 : line_active_q) | blank_q;
    px_d          = blank_q ? x_base + 10'd1 : x_base;
    py_d          = y_base;
    pixel_valid_d = blank_q & (state_q == LOCKED);
    posx_d        = blank_q ? x_base : posx_q;
    posy_d        = blank_q ? y_base : posy_q;
    pixel_rgb_d   = blank_q ? rgb_q : pixel_rgb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEARCH;
      good_cnt_q    <= '0;
      line_cnt_q    <= 10'd0;
      line_num_q    <= 10'd0;
      frame_ok_q    <= 1'b0;
      px_q          <= 10'd0;
      py_q          <= 10'd0;
      line_active_q <= 1'b0;
      pixel_valid_q <= 1'b0;
      posx_q        <= 10'd0;
      posy_q        <= 10'd0;
      pixel_rgb_q   <= 24'd0;
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_num_q    <= line_num_d;
      frame_ok_q    <= frame_ok_d;
      px_q          <= px_d;
      py_q          <= py_d;
      line_active_q <= line_active_d;
      pixel_valid_q <= pixel_valid_d;
      posx_q        <= posx_d;
      posy_q        <= posy_d;
      pixel_rgb_q   <= pixel_rgb_d;
      locked_q      <= locked_d;
      frame_done_q  <= frame_done_d;
      sync_error_q  <= sync_error_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign posx        = posx_q;
  assign posy        = posy_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign locked      = locked_q;
  assign frame_done  = frame_done_q;
  assign sync_error  = sync_error_q;

`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0] sum_acc_q, sum_acc_d, frame_sum_q, frame_sum_d, sum_total;

  // Accumulate on the stage feeding pixel_rgb so frame_sum appears together with frame_done.
  always_comb begin
    sum_total   = sum_acc_q + (pixel_valid_d ? {8'd0, rgb_q} : 32'd0);
    sum_acc_d   = sum_total;
    frame_sum_d = frame_sum_q;
    if (frame_done_d) frame_sum_d = sum_total;
    if (vs_fall || state_q != LOCKED) sum_acc_d = 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_acc_q   <= 32'd0;
      frame_sum_q <= 32'd0;
    end else begin
      sum_acc_q   <= sum_acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = 32'd0;
`endif

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver on a reduced 20x10 raster (12x6 active, lock after 2 frames).
// The driver pushes expected pixels/events with their output cycle; a negedge monitor pops and compares.
module tb_vga_timing_receiver;

  localparam int H = 20;
  localparam int V = 10;
  localparam int LOCKN = 2;
  localparam int EV_DONE = 1;
  localparam int EV_ERR = 2;

  typedef struct {
    int          cyc;
    int          x;
    int          y;
    logic [23:0] c;
  } pix_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] sum;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vga_hs = 1'b1;
  logic        vga_vs = 1'b1;
  logic        vga_blank_n = 1'b0;
  logic [23:0] rgb = 24'd0;
  logic        pixel_valid;
  logic [9:0]  posx, posy;
  logic [23:0] pixel_rgb;
  logic        locked, frame_done, sync_error;
  logic [31:0] frame_sum;

  pix_t        pixQ[$];
  evt_t        evQ[$];
  pix_t        monPix;
  evt_t        monEvt;
  int          cyc = 0;
  int          nChecks = 0;
  int          nPass = 0;
  int          fr = 0;
  int          pendKind = 0;
  logic [31:0] pendSum = 32'd0;
  logic        lockedPrev = 1'b0;

  vga_timing_receiver #(
    .H_TOTAL(H),
    .V_TOTAL(V),
    .LOCK_FRAMES(LOCKN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .rgb(rgb),
    .pixel_valid(pixel_valid),
    .posx(posx),
    .posy(posy),
    .pixel_rgb(pixel_rgb),
    .locked(locked),
    .frame_done(frame_done),
    .sync_error(sync_error),
    .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic noteMissing(input string name);
    nChecks++;
    $display("[TB] FAIL %s: got an output, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic driveCycle(input logic hs, input logic vs, input logic bl, input logic [23:0] c);
    @(posedge clk);
    #1;
    vga_hs      = hs;
    vga_vs      = vs;
    vga_blank_n = bl;
    rgb         = c;
  endtask

  // A pin edge driven in cycle N shows up on the registered outputs in cycle N+2.
  task automatic pushEvent(input int kind, input logic [31:0] s);
    evt_t e;
    e.cyc  = cyc + 2;
    e.kind = kind;
    e.sum  = s;
    evQ.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
    checkOutput({tag, "_locked"}, 32'(locked), 32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_sync_error"}, 32'(sync_error), 32'd0);
    checkOutput({tag, "_posx"}, 32'(posx), 32'd0);
    checkOutput({tag, "_posy"}, 32'(posy), 32'd0);
    checkOutput({tag, "_pixel_rgb"}, 32'(pixel_rgb), 32'd0);
    checkOutput({tag, "_frame_sum"}, frame_sum, 32'd0);
  endtask

  // One raster frame: lines 0-1 VS low, active lines 3..8, active columns 4..15, HS low at columns 0-1.
  task automatic applyStimulus(input int lines, input int badLine, input int badLen,
                               input bit lockedFrame, input bit unitColor,
                               input int rstLine, input int rstX, input int closeKind);
    logic [31:0] sum = 32'd0;
    bit          expPix = lockedFrame;
    int          hold = 0;
    int          len;
    logic        hs, vs, bl;
    logic [23:0] c;
    pix_t        p;
    fr++;
    for (int l = 0; l < lines; l++) begin
      len = (l == badLine) ? badLen : H;
      for (int x = 0; x < len; x++) begin
        hs = (x >= 2);
        vs = (l >= 2);
        bl = (l >= 3) && (l <= 8) && (x >= 4) && (x <= 15);
        c  = unitColor ? 24'h000001 : {8'(fr), 8'(l), 8'(x)};
        driveCycle(hs, vs, bl, c);
        if (hold > 0) begin
          hold--;
          if (hold == 0) rst = 1'b0;
        end
        if (l == 0 && x == 0 && pendKind != 0) begin
          pushEvent(pendKind, pendSum);
          pendKind = 0;
        end
        if (badLine >= 0 && l == badLine + 1 && x == 0) begin
          pushEvent(EV_ERR, 32'd0);
          expPix = 1'b0;
        end
        if (l == rstLine && x == rstX) begin
          checkOutput("pre_rst_locked", 32'(locked), 32'd1);
          checkOutput("pre_rst_posx", 32'(posx), 32'd11);
          checkOutput("pre_rst_posy", 32'(posy), 32'd1);
          rst = 1'b1;
          #1;
          checkAllZero("mid_rst");
          expPix = 1'b0;
          hold = 2;
        end
        if (bl && expPix) begin
          p.cyc = cyc + 2;
          p.x   = x - 4;
          p.y   = l - 3;
          p.c   = c;
          pixQ.push_back(p);
          sum += {8'd0, c};
        end
      end
    end
    pendKind = closeKind;
`ifdef VGA_RX_CHECKSUM_EN
    pendSum = lockedFrame ? sum : 32'd0;
`else
    pendSum = 32'd0;
`endif
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_valid) begin
        if (pixQ.size() == 0) noteMissing("pix_unexpected");
        else begin
          monPix = pixQ.pop_front();
          checkOutput("pix_cycle", cyc, monPix.cyc);
          checkOutput("pix_posx", 32'(posx), monPix.x);
          checkOutput("pix_posy", 32'(posy), monPix.y);
          checkOutput("pix_rgb", 32'(pixel_rgb), 32'(monPix.c));
        end
      end
      if (frame_done || sync_error) begin
        if (evQ.size() == 0) noteMissing("evt_unexpected");
        else begin
          monEvt = evQ.pop_front();
          checkOutput("evt_kind", {30'd0, sync_error, frame_done}, monEvt.kind);
          checkOutput("evt_cycle", cyc, monEvt.cyc);
          if (monEvt.kind == EV_DONE) begin
            checkOutput("done_locked", 32'(locked), 32'd1);
            checkOutput("done_frame_sum", frame_sum, monEvt.sum);
          end else begin
            checkOutput("err_locked", 32'(locked), 32'd0);
          end
        end
      end
      if (locked && !lockedPrev) checkOutput("lock_rise_with_done", 32'(frame_done), 32'd1);
    end
    lockedPrev = locked;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got no end of stimulus, expected finish within 100000 cycles");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    // Acquire lock, then locked frames with pattern and constant-1 pixel data.
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, 0);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, EV_DONE);
    applyStimulus(V, -1, 0, 1'b1, 1'b0, -1, -1, EV_DONE);
    applyStimulus(V, -1, 0, 1'b1, 1'b1, -1, -1, EV_DONE);
    // One line a clock short, then relock.
    applyStimulus(V, 4, H - 1, 1'b1, 1'b0, -1, -1, 0);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, 0);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, EV_DONE);
    // Frame one line short, error at the closing VS edge.
    applyStimulus(V - 1, -1, 0, 1'b1, 1'b0, -1, -1, EV_ERR);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, 0);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, 0);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, EV_DONE);
    // Line of H+1024 clocks: a wrapping counter would see H, a saturating one must not.
    applyStimulus(V, 4, H + 1024, 1'b1, 1'b0, -1, -1, 0);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, 0);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, EV_DONE);
    applyStimulus(V, -1, 0, 1'b1, 1'b0, -1, -1, EV_DONE);
    // Reset mid-line while locked; lock returns two full frames after the next VS edge.
    applyStimulus(V, -1, 0, 1'b1, 1'b0, 5, 2, 0);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, 0);
    applyStimulus(V, -1, 0, 1'b0, 1'b0, -1, -1, EV_DONE);
    applyStimulus(V, -1, 0, 1'b1, 1'b0, -1, -1, EV_DONE);
    driveCycle(1'b0, 1'b0, 1'b0, 24'd0);
    if (pendKind != 0) pushEvent(pendKind, pendSum);
    pendKind = 0;
    repeat (8) driveCycle(1'b1, 1'b1, 1'b0, 24'd0);
    checkOutput("pix_queue_drained", pixQ.size(), 32'd0);
    checkOutput("evt_queue_drained", evQ.size(), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
